mem_ctrl: RTL and testbench

Byte-serial memory controller between the 8-bit RAM/IO bus and the CPU's two memory clients: the instruction fetcher and the load/store buffer (LSB). It serves 32-bit instruction reads for the fetcher over `instr_mc2if`, and 1/2/4-byte data reads and writes for the LSB. It arbitrates between the two clients, stalls I/O writes on `io_buffer_full`, and aborts speculative reads on pipeline flush.

---
 rtl/mem_ctrl_pkg.sv | 34 +++
 rtl/mem_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states,
// access sizes and the I/O region decode.
package mem_ctrl_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_IF_READ,
    MC_LSB_READ,
    MC_LSB_WRITE
  } mc_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int unsigned IO_ADDR_HI = 17;
  localparam int unsigned IO_ADDR_LO = 16;

  // Illegal size 3 is treated as a word access.
  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [DATA_W-1:0] addr);
    return addr[IO_ADDR_HI:IO_ADDR_LO] == 2'b11;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO bus controller serving the instruction fetcher and the
// load/store buffer, with LSB priority, I/O write stalls and flush support.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rdy,
  input  logic              clear,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [DATA_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              mc_if_done,
  output logic [DATA_W-1:0] instr_mc2if,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [DATA_W-1:0] lsb_addr,
  input  logic [1:0]        lsb_size,
  input  logic [DATA_W-1:0] lsb_wdata,
  output logic              mc_lsb_done,
  output logic [DATA_W-1:0] lsb_rdata
);

  mc_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_done_q, if_done_d;
  logic              lsb_done_q, lsb_done_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [2:0]        k;
  logic [DATA_W-1:0] next_a;
  logic [DATA_W-1:0] asm_new;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = 1'b0;
    lsb_done_d = 1'b0;
    instr_d    = instr_q;
    rdata_d    = rdata_q;

    k       = cnt_q + 3'd1;
    next_a  = base_q + DATA_W'(k);
    asm_new = asm_q;
    asm_new[{cnt_q[1:0], 3'b000} +: 8] = mem_din;

    case (state_q)
      MC_IDLE: begin
        // A client whose done pulse is still visible has not yet dropped its request.
        if (!clear) begin
          if (lsb_req && !lsb_done_q) begin
            base_d  = lsb_addr;
            len_d   = size_len(lsb_size);
            cnt_d   = '0;
            asm_d   = '0;
            wdata_d = lsb_wdata;
            mem_a_d = lsb_addr;
            if (lsb_wr) begin
              state_d    = MC_LSB_WRITE;
              mem_dout_d = lsb_wdata[7:0];
              mem_wr_d   = !(is_io(lsb_addr) && io_buffer_full);
            end else begin
              state_d  = MC_LSB_READ;
              mem_wr_d = 1'b0;
            end
          end else if (if_req && !if_done_q) begin
            state_d  = MC_IF_READ;
            base_d   = if_addr;
            len_d    = 3'd4;
            cnt_d    = '0;
            asm_d    = '0;
            mem_a_d  = if_addr;
            mem_wr_d = 1'b0;
          end
        end
      end

      MC_IF_READ, MC_LSB_READ: begin
        if (clear) begin
          state_d = MC_IDLE;
          cnt_d   = '0;
          mem_a_d = '0;
        end else begin
          asm_d = asm_new;
          cnt_d = k;
          if (k == len_q) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
            mem_a_d = '0;
            if (state_q == MC_IF_READ) begin
              instr_d   = asm_new;
              if_done_d = 1'b1;
            end else begin
              rdata_d    = asm_new;
              lsb_done_d = 1'b1;
            end
          end else begin
            mem_a_d = next_a;
          end
        end
      end

      MC_LSB_WRITE: begin
        // A byte counts as committed only on an edge where mem_wr was actually driven.
        if (mem_wr_q) begin
          cnt_d = k;
          if (k == len_q) begin
            state_d    = MC_IDLE;
            cnt_d      = '0;
            mem_wr_d   = 1'b0;
            lsb_done_d = 1'b1;
          end else begin
            mem_a_d    = next_a;
            mem_dout_d = wdata_q[{k[1:0], 3'b000} +: 8];
            mem_wr_d   = !(is_io(next_a) && io_buffer_full);
          end
        end else begin
          mem_wr_d = !(is_io(mem_a_q) && io_buffer_full);
        end
      end

      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MC_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      lsb_done_q <= 1'b0;
      instr_q    <= '0;
      rdata_q    <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      lsb_done_q <= lsb_done_d;
      instr_q    <= instr_d;
      rdata_q    <= rdata_d;
    end
  end

  // While frozen the pending write byte stays registered and reappears with rdy.
  assign mem_wr      = mem_wr_q & rdy;
  assign mc_if_done  = if_done_q & rdy;
  assign mc_lsb_done = lsb_done_q & rdy;
  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign instr_mc2if = instr_q;
  assign lsb_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed bus scenarios plus randomized
// fetch/load/store traffic against a byte-array memory model.
module tb_mem_ctrl;

  localparam int RAM_N = 1 << 18;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mc_if_done;
  logic [31:0] instr_mc2if;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [1:0]  lsb_size = '0;
  logic [31:0] lsb_wdata = '0;
  logic        mc_lsb_done;
  logic [31:0] lsb_rdata;

  mem_ctrl dut (
    .clk(clk), .reset(reset), .rdy(rdy), .clear(clear),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .mc_if_done(mc_if_done), .instr_mc2if(instr_mc2if),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
    .lsb_wdata(lsb_wdata), .mc_lsb_done(mc_lsb_done), .lsb_rdata(lsb_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int unsigned a);
    case (a)
      32'h1000: return 8'h13;
      32'h1001: return 8'h05;
      32'h1002: return 8'h10;
      32'h1003: return 8'h00;
      32'h2000: return 8'hAB;
      default:  return 8'((a * 7) ^ (a >> 5) ^ 32'h5A);
    endcase
  endfunction

  // Bus-side memory: combinational read, write on the edge while mem_wr is high.
  logic [7:0]  ram [0:RAM_N-1];
  logic        ram_fill = 1'b1;
  logic [31:0] wl_a [0:1023];
  logic [7:0]  wl_d [0:1023];
  int          wl_n = 0;

  assign mem_din = ram[mem_a[17:0]];

  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < RAM_N; i++) ram[i] <= init_byte(i);
    end else if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
    end
    if (mem_wr) begin
      wl_a[wl_n % 1024] <= mem_a;
      wl_d[wl_n % 1024] <= mem_dout;
      wl_n <= wl_n + 1;
    end
  end

  // Reference contents of the memory as the clients should see it.
  logic [7:0]  shadow [0:RAM_N-1];
  logic [31:0] last_instr = '0;
  logic [31:0] last_rdata = '0;
  int          n_checks = 0;
  int          n_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // kind 0 = fetch, 1 = load, 2 = store. io_buffer_full is high for the first
  // f edges from acceptance; rdy is low for edges s..s+g-1 after acceptance.
  task automatic run_txn(input int kind, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input int f, input int s, input int g);
    int          len, lat, e, n, w0;
    logic [31:0] exp, ai;
    bit          seen, done_now;
    len = (kind == 0) ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp = '0;
    for (int i = 0; i < len; i++) begin
      ai = a + 32'(i);
      exp[8*i +: 8] = shadow[ai[17:0]];
    end
    lat = len;
    if (kind == 2) begin
      e = 0;
      for (int i = 0; i < len; i++) begin
        ai = a + 32'(i);
        while (e < f && ai[17:16] == 2'b11) e++;
        e++;
      end
      lat = e;
    end
    lat += g;
    w0 = wl_n;

    @(negedge clk);
    if (kind == 0) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      lsb_req = 1'b1; lsb_wr = (kind == 2); lsb_addr = a; lsb_size = sz; lsb_wdata = wd;
    end
    io_buffer_full = (f > 0);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      done_now = (kind == 0) ? mc_if_done : mc_lsb_done;
      if (g == 0 && f == 0 && n <= len) begin
        ai = a + 32'(n - 1);
        check("bus_addr", mem_a, ai);
        if (kind == 2) begin
          check("bus_wr", 32'(mem_wr), 32'd1);
          check("bus_dout", 32'(mem_dout), 32'(wd[8*(n-1) +: 8]));
        end
      end
      if (done_now) begin
        seen = 1;
        if (kind != 2) check("idle_addr", mem_a, 32'h0);
      end else begin
        io_buffer_full = (n < f);
        rdy = !(g > 0 && n >= s && n < s + g);
      end
    end
    check("latency", 32'(n - 1), 32'(lat));
    if_req = 1'b0; lsb_req = 1'b0; io_buffer_full = 1'b0; rdy = 1'b1;
    @(negedge clk);
    check("done_pulse", 32'(mc_if_done | mc_lsb_done), 32'd0);

    if (kind == 0) begin
      check("instr", instr_mc2if, exp);
      check("rdata_hold", lsb_rdata, last_rdata);
      last_instr = exp;
    end else if (kind == 1) begin
      check("rdata", lsb_rdata, exp);
      check("instr_hold", instr_mc2if, last_instr);
      last_rdata = exp;
    end else begin
      check("wr_count", 32'(wl_n - w0), 32'(len));
      for (int i = 0; i < len; i++) begin
        ai = a + 32'(i);
        check("wr_addr", wl_a[(w0 + i) % 1024], ai);
        check("wr_data", 32'(wl_d[(w0 + i) % 1024]), 32'(wd[8*i +: 8]));
        shadow[ai[17:0]] = wd[8*i +: 8];
      end
      check("rdata_hold", lsb_rdata, last_rdata);
      check("instr_hold", instr_mc2if, last_instr);
    end
  endtask

  initial begin
    int lsb_n, if_n, dcount, kind, f, s, g, len;
    logic [31:0] a, wd;
    logic [1:0]  sz;

    for (int i = 0; i < RAM_N; i++) shadow[i] = init_byte(i);
    repeat (3) @(negedge clk);
    ram_fill = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_dout", 32'(mem_dout), 32'h0);
    check("rst_wr", 32'(mem_wr), 32'h0);
    check("rst_if_done", 32'(mc_if_done), 32'h0);
    check("rst_lsb_done", 32'(mc_lsb_done), 32'h0);
    check("rst_instr", instr_mc2if, 32'h0);
    check("rst_rdata", lsb_rdata, 32'h0);

    // Fetch of a known instruction word
    run_txn(0, 32'h1000, 2'd2, '0, 0, 0, 0);
    check("fetch_instr", instr_mc2if, 32'h00100513);

    // Simultaneous requests: LSB first, fetch accepted on the following cycle
    @(negedge clk);
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h2000; lsb_size = 2'd0;
    if_req = 1'b1; if_addr = 32'h1000;
    lsb_n = 0; if_n = 0;
    for (int n = 1; n <= 20 && if_n == 0; n++) begin
      @(negedge clk);
      if (mc_lsb_done) begin lsb_n = n; lsb_req = 1'b0; end
      if (mc_if_done) begin if_n = n; if_req = 1'b0; end
    end
    if_req = 1'b0; lsb_req = 1'b0;
    check("cont_lsb_time", 32'(lsb_n), 32'd2);
    check("cont_rdata", lsb_rdata, 32'h000000AB);
    check("cont_if_time", 32'(if_n), 32'd7);
    check("cont_instr", instr_mc2if, 32'h00100513);
    last_rdata = 32'h000000AB;
    @(negedge clk);

    // Half store, unaligned
    run_txn(2, 32'h3001, 2'd1, 32'h1234BEEF, 0, 0, 0);
    check("st_h_b1", 32'(ram[18'h3001]), 32'hEF);
    check("st_h_b2", 32'(ram[18'h3002]), 32'hBE);

    // I/O write held off by a full buffer, and non-I/O store not held off
    run_txn(2, 32'h00030000, 2'd0, 32'h41, 3, 0, 0);
    check("io_byte", 32'(ram[18'h30000]), 32'h41);
    run_txn(2, 32'h00020010, 2'd2, 32'h89ABCDEF, 3, 0, 0);

    // Flush at the second edge of a fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h1000;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; if_req = 1'b0;
    check("flush_addr", mem_a, 32'h0);
    dcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (mc_if_done) dcount++;
    end
    check("flush_no_done", 32'(dcount), 32'd0);
    check("flush_wr", 32'(mem_wr), 32'd0);
    check("flush_instr_hold", instr_mc2if, last_instr);
    run_txn(0, 32'h1000, 2'd2, '0, 0, 0, 0);

    // Request on a clear edge while idle is ignored
    @(negedge clk);
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h2000; lsb_size = 2'd0; clear = 1'b1;
    @(negedge clk);
    lsb_req = 1'b0; clear = 1'b0;
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (mc_lsb_done) dcount++;
    end
    check("clear_idle_no_done", 32'(dcount), 32'd0);

    // rdy low for two cycles in the middle of a word load
    run_txn(1, 32'h00001000, 2'd2, '0, 0, 2, 2);

    // Address wrap across 2^32
    run_txn(2, 32'hFFFFFFFF, 2'd1, 32'h00005AA5, 0, 0, 0);
    run_txn(1, 32'hFFFFFFFF, 2'd1, '0, 0, 0, 0);

    // Asynchronous reset in the middle of a word store
    @(negedge clk);
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h4000; lsb_size = 2'd2; lsb_wdata = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    lsb_req = 1'b0;
    check("arst_wr", 32'(mem_wr), 32'd0);
    check("arst_mem_a", mem_a, 32'h0);
    check("arst_dout", 32'(mem_dout), 32'h0);
    check("arst_done", 32'(mc_if_done | mc_lsb_done), 32'd0);
    check("arst_instr", instr_mc2if, 32'h0);
    check("arst_rdata", lsb_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    shadow[18'h4000] = 8'h0D;
    last_instr = '0;
    last_rdata = '0;
    check("arst_b0", 32'(ram[18'h4000]), 32'h0D);
    check("arst_b1", 32'(ram[18'h4001]), 32'(shadow[18'h4001]));
    run_txn(1, 32'h00004000, 2'd2, '0, 0, 0, 0);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 2);
      a    = $urandom;
      if (kind == 0) a[1:0] = 2'b00;
      sz   = 2'($urandom_range(0, 2));
      wd   = $urandom;
      len  = (kind == 0) ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      f = 0; s = 0; g = 0;
      case ($urandom_range(0, 2))
        0: f = $urandom_range(1, 3);
        1: begin s = $urandom_range(1, len); g = $urandom_range(1, 3); end
        default: ;
      endcase
      run_txn(kind, a, sz, wd, f, s, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
